regfile_dump: RTL and testbench

- Debug read-out engine that sits on one read port of the register file, opposite the writeback side.
- On a start pulse it walks a contiguous range of registers (wrapping mod NUM_REGS) by driving the read address.
- It captures the combinational read data and streams each register as a valid/ready beat, tagged with its index.
- Used by the debug/trace path and by benches to dump architectural state without stalling the core's own read ports.

---
 rtl/regfile_dump.sv | 111 +++++++++++
 tb/tb_regfile_dump.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// Debug read-out engine: walks a register range on one read port
// and streams each value as a valid/ready beat tagged with its index.
module regfile_dump #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_ad,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] rd_ad,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_t;

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(NUM_REGS);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   cnt_clamp;
    logic              load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        valid_d   = valid_q;
        data_d    = data_q;
        idx_d     = idx_q;
        cnt_clamp = (count > MAX_CNT) ? MAX_CNT : count;
        load      = !valid_q || out_ready;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d   = first_ad;
                    rem_d   = cnt_clamp;
                    state_d = (cnt_clamp == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                // Capture only into a free or departing slot so a held beat stays stable
                if (load) begin
                    data_d  = rd_data;
                    idx_d   = ptr_q;
                    valid_d = 1'b1;
                    ptr_d   = ptr_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    if (rem_q == (ADDR_W+1)'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rd_ad     = ptr_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_index = idx_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: directed dumps against a
// behavioural register file, beats checked by a separate monitor.
module tb_regfile_dump;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] first_ad;
    logic [AW:0]   count;
    logic [AW-1:0] rd_ad;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_index;
    logic          busy;
    logic          done;

    logic [DW-1:0] regs [NR];

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    regfile_dump #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .first_ad  (first_ad),
        .count     (count),
        .rd_ad     (rd_ad),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .busy      (busy),
        .done      (done)
    );

    assign rd_data = regs[rd_ad];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_dump(input int f, input int c);
        beat_t b;
        int    n;
        n = (c > NR) ? NR : c;
        for (int i = 0; i < n; i++) begin
            b.idx  = AW'((f + i) % NR);
            b.data = regs[(f + i) % NR];
            exp_q.push_back(b);
        end
    endtask

    task automatic issue(input int f, input int c);
        first_ad = AW'(f);
        count    = (AW+1)'(c);
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        while (!done && cyc < limit) begin
            step();
            cyc++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=%0d required<%0d", cyc, limit);
        end
    endtask

    // Monitor: every accepted beat is popped and compared
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (out_valid || done) begin
                check("done_valid_excl", 64'(done && out_valid), 64'd0);
            end
            if (reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=idx %0d required=none",
                             out_index);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_index", 64'(out_index), 64'(e.idx));
                    check("beat_data", 64'(out_data), 64'(e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        reset     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        first_ad  = '0;
        count     = '0;
        for (int i = 0; i < NR; i++) regs[i] = '0;
        regs[9]  = 32'hAFAE2E03;
        regs[20] = 32'hFF34A018;
        regs[30] = 32'h1010AAEF;

        step();
        step();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_index", 64'(out_index), 64'd0);
        check("rst_rd_ad", 64'(rd_ad), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            out_ready = (i != 1);
            step();
            check("idle_valid", 64'(out_valid), 64'd0);
        end

        out_ready = 1'b1;
        push_dump(0, 32);
        issue(0, 32);
        check("full_rd_ad", 64'(rd_ad), 64'd0);
        check("full_busy", 64'(busy), 64'd1);
        wait_done(40, cyc);
        check("full_done_cycle", 64'(cyc), 64'd33);
        check("full_drained", 64'(exp_q.size()), 64'd0);
        step();
        check("full_busy_low", 64'(busy), 64'd0);

        push_dump(30, 4);
        issue(30, 4);
        check("wrap_rd_ad", 64'(rd_ad), 64'd30);
        wait_done(10, cyc);
        check("wrap_done_cycle", 64'(cyc), 64'd5);
        check("wrap_drained", 64'(exp_q.size()), 64'd0);
        step();

        push_dump(5, 40);
        issue(5, 40);
        wait_done(50, cyc);
        check("clamp_done_cycle", 64'(cyc), 64'd33);
        check("clamp_drained", 64'(exp_q.size()), 64'd0);
        step();

        issue(3, 0);
        wait_done(4, cyc);
        check("zero_done_cycle", 64'(cyc), 64'd0);
        check("zero_busy", 64'(busy), 64'd1);
        step();
        check("zero_done_low", 64'(done), 64'd0);
        check("zero_busy_low", 64'(busy), 64'd0);
        check("zero_valid", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        push_dump(20, 3);
        issue(20, 3);
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_data", 64'(out_data), 64'hFF34A018);
            check("bp_index", 64'(out_index), 64'd20);
            step();
        end
        out_ready = 1'b1;
        wait_done(10, cyc);
        check("bp_drained", 64'(exp_q.size()), 64'd0);
        step();

        out_ready = 1'b0;
        issue(20, 8);
        step();
        regs[25] = 32'h12345678;
        push_dump(20, 8);
        step();
        out_ready = 1'b1;
        wait_done(15, cyc);
        check("wr_drained", 64'(exp_q.size()), 64'd0);
        step();

        push_dump(0, 6);
        issue(0, 6);
        step();
        step();
        issue(10, 5);
        wait_done(15, cyc);
        check("ign_drained", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < 5; i++) step();
        check("ign_busy", 64'(busy), 64'd0);
        check("ign_valid", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        issue(0, 10);
        step();
        step();
        check("abort_pre_valid", 64'(out_valid), 64'd1);
        reset = 1'b0;
        #1;
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_rd_ad", 64'(rd_ad), 64'd0);
        exp_q.delete();
        step();
        reset = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("abort_no_done", 64'(done), 64'd0);
        end
        check("abort_idle", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
